// File: rtl/sad_acc_pkg.sv
// Shared types and width helpers for the SAD accumulate/minimum stage.
// Contents:
//   state_t      : search FSM states (ACCUM collects beats, DONE presents result)
//   acc_w/idx_w  : derived accumulator and candidate-index widths
//   SAD_ALL_ONES : all-ones SAD constant, sliced to ACC_W by users
package sad_acc_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  localparam int unsigned SAD_MAX_W = 32;
  localparam logic [SAD_MAX_W-1:0] SAD_ALL_ONES = '1;

  // Sum of BEATS values of sad_w bits never exceeds sad_w + log2(BEATS) bits.
  function automatic int unsigned acc_w(input int unsigned sad_w, input int unsigned beats);
    return sad_w + $clog2(beats);
  endfunction

  function automatic int unsigned idx_w(input int unsigned cands);
    return $clog2(cands);
  endfunction

endpackage

// File: rtl/sad_min_tracker.sv
// Combinational best (and optionally second-best) update for one closed
// candidate SAD.
// Optional feature macro: SAD_ACC_SECOND_BEST_EN (adds second_sad tracking).
// Ports:
//   first          : candidate is the first of the search (unconditional load)
//   cand, cand_idx : closed candidate SAD and its index
//   best_sad/idx   : current best
//   second_sad     : current second-smallest (macro only)
//   *_nxt          : updated values
module sad_min_tracker
  import sad_acc_pkg::*;
#(
  parameter int unsigned ACC_W = 7,
  parameter int unsigned IDX_W = 3
) (
  input  logic             first,
  input  logic [ACC_W-1:0] cand,
  input  logic [IDX_W-1:0] cand_idx,
  input  logic [ACC_W-1:0] best_sad,
  input  logic [IDX_W-1:0] best_idx,
`ifdef SAD_ACC_SECOND_BEST_EN
  input  logic [ACC_W-1:0] second_sad,
  output logic [ACC_W-1:0] second_sad_nxt,
`endif
  output logic [ACC_W-1:0] best_sad_nxt,
  output logic [IDX_W-1:0] best_idx_nxt
);

  // Strict less-than keeps the earlier index on ties.
  always_comb begin
    best_sad_nxt   = best_sad;
    best_idx_nxt   = best_idx;
`ifdef SAD_ACC_SECOND_BEST_EN
    second_sad_nxt = second_sad;
`endif
    if (first) begin
      best_sad_nxt   = cand;
      best_idx_nxt   = cand_idx;
`ifdef SAD_ACC_SECOND_BEST_EN
      second_sad_nxt = SAD_ALL_ONES[ACC_W-1:0];
`endif
    end else if (cand < best_sad) begin
      best_sad_nxt   = cand;
      best_idx_nxt   = cand_idx;
`ifdef SAD_ACC_SECOND_BEST_EN
      second_sad_nxt = best_sad;
`endif
    end
`ifdef SAD_ACC_SECOND_BEST_EN
    else if (cand < second_sad) begin
      second_sad_nxt = cand;
    end
`endif
  end

endmodule

// File: rtl/sad_acc_min.sv
// Accumulates BEATS partial SADs per candidate, tracks the minimum over CANDS
// candidates and presents the result with a valid/ready handshake.
// Optional feature macro: SAD_ACC_SECOND_BEST_EN (adds out_second_sad).
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : partial-SAD beat handshake
//   in_sad                : partial SAD (unsigned)
//   out_valid/out_ready   : result handshake
//   out_min_sad           : minimum candidate SAD
//   out_best_idx          : index of minimum candidate
//   out_second_sad        : second-smallest SAD (macro only)
module sad_acc_min
  import sad_acc_pkg::*;
#(
  parameter  int unsigned BEATS = 16,
  parameter  int unsigned CANDS = 8,
  parameter  int unsigned SAD_W = 3,
  localparam int unsigned ACC_W = acc_w(SAD_W, BEATS),
  localparam int unsigned IDX_W = idx_w(CANDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SAD_W-1:0] in_sad,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_min_sad,
`ifdef SAD_ACC_SECOND_BEST_EN
  output logic [ACC_W-1:0] out_second_sad,
`endif
  output logic [IDX_W-1:0] out_best_idx
);

  localparam int unsigned BCNT_W = $clog2(BEATS);
  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEATS - 1);
  localparam logic [IDX_W-1:0]  LAST_CAND = IDX_W'(CANDS - 1);

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [IDX_W-1:0]  ccnt_q, ccnt_d;
  logic [ACC_W-1:0]  best_sad_q, best_sad_d;
  logic [IDX_W-1:0]  best_idx_q, best_idx_d;
  logic [ACC_W-1:0]  out_min_q, out_min_d;
  logic [IDX_W-1:0]  out_idx_q, out_idx_d;
`ifdef SAD_ACC_SECOND_BEST_EN
  logic [ACC_W-1:0]  second_q, second_d;
  logic [ACC_W-1:0]  out_second_q, out_second_d;
  logic [ACC_W-1:0]  trk_second;
`endif

  logic             beat_acc;
  logic [ACC_W-1:0] cand;
  logic [ACC_W-1:0] trk_best_sad;
  logic [IDX_W-1:0] trk_best_idx;

  assign in_ready = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign beat_acc = in_valid && (state_q == ACCUM);
  assign cand = acc_q + ACC_W'(in_sad);

  sad_min_tracker #(
    .ACC_W(ACC_W),
    .IDX_W(IDX_W)
  ) u_tracker (
    .first         (ccnt_q == '0),
    .cand          (cand),
    .cand_idx      (ccnt_q),
    .best_sad      (best_sad_q),
    .best_idx      (best_idx_q),
`ifdef SAD_ACC_SECOND_BEST_EN
    .second_sad    (second_q),
    .second_sad_nxt(trk_second),
`endif
    .best_sad_nxt  (trk_best_sad),
    .best_idx_nxt  (trk_best_idx)
  );

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    bcnt_d       = bcnt_q;
    ccnt_d       = ccnt_q;
    best_sad_d   = best_sad_q;
    best_idx_d   = best_idx_q;
    out_min_d    = out_min_q;
    out_idx_d    = out_idx_q;
`ifdef SAD_ACC_SECOND_BEST_EN
    second_d     = second_q;
    out_second_d = out_second_q;
`endif
    case (state_q)
      ACCUM: begin
        if (beat_acc) begin
          if (bcnt_q != LAST_BEAT) begin
            acc_d  = cand;
            bcnt_d = bcnt_q + 1'b1;
          end else begin
            // Candidate close: the tracker's next values already include this
            // candidate, so the final one feeds the output registers directly.
            acc_d      = '0;
            bcnt_d     = '0;
            best_sad_d = trk_best_sad;
            best_idx_d = trk_best_idx;
`ifdef SAD_ACC_SECOND_BEST_EN
            second_d   = trk_second;
`endif
            if (ccnt_q == LAST_CAND) begin
              state_d      = DONE;
              ccnt_d       = '0;
              out_min_d    = trk_best_sad;
              out_idx_d    = trk_best_idx;
`ifdef SAD_ACC_SECOND_BEST_EN
              out_second_d = trk_second;
`endif
            end else begin
              ccnt_d = ccnt_q + 1'b1;
            end
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ACCUM;
      acc_q        <= '0;
      bcnt_q       <= '0;
      ccnt_q       <= '0;
      best_sad_q   <= '0;
      best_idx_q   <= '0;
      out_min_q    <= '0;
      out_idx_q    <= '0;
`ifdef SAD_ACC_SECOND_BEST_EN
      second_q     <= '0;
      out_second_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      bcnt_q       <= bcnt_d;
      ccnt_q       <= ccnt_d;
      best_sad_q   <= best_sad_d;
      best_idx_q   <= best_idx_d;
      out_min_q    <= out_min_d;
      out_idx_q    <= out_idx_d;
`ifdef SAD_ACC_SECOND_BEST_EN
      second_q     <= second_d;
      out_second_q <= out_second_d;
`endif
    end
  end

  assign out_min_sad  = out_min_q;
  assign out_best_idx = out_idx_q;
`ifdef SAD_ACC_SECOND_BEST_EN
  assign out_second_sad = out_second_q;
`endif

endmodule

// File: tb/tb_sad_acc_min.sv
module tb_sad_acc_min;

  localparam int BEATS = 16;
  localparam int CANDS = 8;
  localparam int NB    = BEATS * CANDS;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_sad;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] out_min_sad;
  logic [2:0] out_best_idx;
`ifdef SAD_ACC_SECOND_BEST_EN
  logic [6:0] out_second_sad;
`endif

  int errors = 0;
  int checks = 0;

  logic [2:0] vals [NB];
  int exp_min, exp_idx, exp_sec;

  always #5 clk = ~clk;

  sad_acc_min #(.BEATS(BEATS), .CANDS(CANDS), .SAD_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sad      (in_sad),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_min_sad (out_min_sad),
`ifdef SAD_ACC_SECOND_BEST_EN
    .out_second_sad(out_second_sad),
`endif
    .out_best_idx(out_best_idx)
  );

  // Reference: per-candidate sums; minimum with earliest index on ties;
  // second = smallest value among all candidates other than the winner.
  task automatic model();
    int sums [CANDS];
    for (int c = 0; c < CANDS; c++) begin
      sums[c] = 0;
      for (int b = 0; b < BEATS; b++) sums[c] += int'(vals[c*BEATS+b]);
    end
    exp_min = sums[0];
    exp_idx = 0;
    for (int c = 1; c < CANDS; c++)
      if (sums[c] < exp_min) begin exp_min = sums[c]; exp_idx = c; end
    exp_sec = 127;
    for (int c = 0; c < CANDS; c++)
      if (c != exp_idx && sums[c] < exp_sec) exp_sec = sums[c];
  endtask

  task automatic fill_const(input int v);
    for (int i = 0; i < NB; i++) vals[i] = 3'(v);
  endtask

  task automatic fill_rand(input int lo);
    for (int i = 0; i < NB; i++) vals[i] = 3'($urandom_range(7, lo));
  endtask

  // Drives vals[0..n-1] starting at the current negedge; gap_pct percent chance
  // of an idle cycle (with junk in_sad) before each beat. Returns cycles used
  // and the number of beat cycles that saw in_ready low.
  task automatic drive_beats(input int n, input int gap_pct, output int used, output int not_ready);
    used = 0;
    not_ready = 0;
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
        in_sad   = 3'($urandom);
        if (in_ready !== 1'b1) not_ready++;
        @(negedge clk); used++;
      end
      in_valid = 1'b1;
      in_sad   = vals[i];
      if (in_ready !== 1'b1) not_ready++;
      @(negedge clk); used++;
    end
    in_valid = 1'b0;
    in_sad   = 3'($urandom);
  endtask

  task automatic wait_result(output int waited, output logic got);
    waited = 0;
    while (out_valid !== 1'b1 && waited < 40) begin
      @(negedge clk); waited++;
    end
    got = out_valid;
  endtask

  task automatic check_result(input string name);
    checks++;
    if (out_min_sad !== 7'(exp_min)) begin
      errors++;
      $display("FAIL %s min_sad: got %0d expected %0d", name, out_min_sad, exp_min);
    end
    checks++;
    if (out_best_idx !== 3'(exp_idx)) begin
      errors++;
      $display("FAIL %s best_idx: got %0d expected %0d", name, out_best_idx, exp_idx);
    end
`ifdef SAD_ACC_SECOND_BEST_EN
    checks++;
    if (out_second_sad !== 7'(exp_sec)) begin
      errors++;
      $display("FAIL %s second_sad: got %0d expected %0d", name, out_second_sad, exp_sec);
    end
`endif
  endtask

  // One full search with result capture; valid-timeout and readiness checked here.
  task automatic run_search(input string name, input int gap_pct, output int used, output int waited);
    int nr;
    logic got;
    model();
    drive_beats(NB, gap_pct, used, nr);
    checks++;
    if (nr != 0) begin
      errors++;
      $display("FAIL %s in_ready_low_in_accum: got %0d cycles expected 0", name, nr);
    end
    wait_result(waited, got);
    checks++;
    if (got !== 1'b1) begin
      errors++;
      $display("FAIL %s out_valid_timeout: got %b expected 1", name, got);
    end
    check_result(name);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_sad = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b expected 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
    checks++;
    if (out_min_sad !== 7'd0) begin errors++; $display("FAIL reset out_min_sad: got %0d expected 0", out_min_sad); end
    checks++;
    if (out_best_idx !== 3'd0) begin errors++; $display("FAIL reset out_best_idx: got %0d expected 0", out_best_idx); end
`ifdef SAD_ACC_SECOND_BEST_EN
    checks++;
    if (out_second_sad !== 7'd0) begin errors++; $display("FAIL reset out_second_sad: got %0d expected 0", out_second_sad); end
`endif
  endtask

  task automatic test_all_ones();
    int used, waited;
    out_ready = 1'b1;
    fill_const(1);
    run_search("all_ones", 0, used, waited);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL all_ones in_ready_return: got %b expected 1", in_ready); end
    checks++;
    if (used + waited + 1 != NB + 1) begin
      errors++;
      $display("FAIL all_ones period: got %0d cycles expected %0d", used + waited + 1, NB + 1);
    end
  endtask

  task automatic test_cand5();
    int used, waited;
    fill_const(7);
    for (int b = 0; b < BEATS; b++) vals[5*BEATS+b] = 3'd2;
    run_search("cand5", 0, used, waited);
    @(negedge clk);
  endtask

  task automatic test_max_gaps();
    int used, waited;
    fill_const(7);
    run_search("max_gaps", 30, used, waited);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      fill_rand(0);
      run_search("random_gaps", 25, used, waited);
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    int used, waited;
    logic [6:0] hold_min;
    logic [2:0] hold_idx;
    int bad;
    out_ready = 1'b0;
    fill_rand(0);
    run_search("bp", 0, used, waited);
    hold_min = 7'(exp_min);
    hold_idx = 3'(exp_idx);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_sad   = 3'($urandom);
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          out_min_sad !== hold_min || out_best_idx !== hold_idx) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp hold_stable: got %0d bad cycles expected 0", bad); end
    // Beat presented during the handshake cycle must be ignored.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_sad    = 3'd7;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp in_ready_after: got %b expected 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp out_valid_after: got %b expected 0", out_valid); end
    fill_rand(0);
    run_search("bp_next", 10, used, waited);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int used, nr, waited;
    fill_const(0);
    out_ready = 1'b1;
    drive_beats(3*BEATS + 9, 0, used, nr);
    rst = 1'b1;
    in_valid = 1'b1;
    in_sad = 3'd0;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid out_valid: got %b expected 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid in_ready: got %b expected 1", in_ready); end
    fill_rand(1);
    run_search("rst_mid", 0, used, waited);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int used, waited;
    out_ready = 1'b1;
    fill_const(7);
    for (int b = 0; b < BEATS; b++) vals[b] = 3'd0;
    run_search("b2b_first", 0, used, waited);
    @(negedge clk);
    fill_const(7);
    for (int b = 0; b < BEATS; b++) vals[7*BEATS+b] = 3'd1;
    run_search("b2b_second", 0, used, waited);
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_cand5();
    test_max_gaps();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
